pipe_em_elastic: RTL
====================

Name: pipe_em_elastic

Overview:
- Parametrised, elastic EX/MEM pipeline register for the pipelined CPU datapath.
- Carries the ALU result, store data, destination register number and the wreg/m2reg/wmem control bits from EX to MEM.
- Adds a valid/ready handshake, an optional skid entry so stalls need no combinational ready path, and a synchronous flush that turns queued entries into bubbles.
- A bubble never writes the register file or memory.

Parameters:
- ALU_W, 32, width of ealu/malu.
- DATA_W, 32, width of eb/mb (store data).
- RN_W, 5, width of ern/mrn (destination register number).
- SKID, 1, 1 = main entry plus skid entry (registered in_ready); 0 = single entry (combinational in_ready).

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries and of the current input.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- ewreg  in  1  register-write control.
- em2reg  in  1  memory-to-register select.
- ewmem  in  1  memory-write control.
- ealu  in  ALU_W  ALU result.
- eb  in  DATA_W  store data.
- ern  in  RN_W  destination register.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM stage consumes this cycle.
- mwreg, mm2reg, mwmem  out  1 each  control bits, gated by out_valid.
- malu  out  ALU_W  held ALU result.
- mb  out  DATA_W  held store data.
- mrn  out  RN_W  held destination register.
- occ  out  2  entries held (0..2).

Behaviour:
- Storage:
  - Main entry M (valid bit, 3 control bits, alu, b, rn) drives the outputs.
  - Skid entry S has the same fields; present only when SKID=1.
- Reset (clrn low, asynchronous, immediate, including mid-transfer):
  - M and S valid bits = 0; all stored fields = 0.
  - Hence out_valid=0, mwreg=mm2reg=mwmem=0, malu=mb=mrn=0, occ=0.
  - in_ready = 1.
- Events:
  - accept = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready.
- Outputs:
  - out_valid = M.valid.
  - mwreg/mm2reg/mwmem = stored bit AND M.valid.
  - malu/mb/mrn = M fields. These hold their last value while M is invalid and are not cleared by a pop.
- SKID=1:
  - in_ready = !S.valid. It is a register output with no combinational path from out_ready.
  - occ = M.valid + S.valid.
- SKID=1 state machine (EMPTY occ=0, ONE occ=1, FULL occ=2), evaluated on rising clk:
  - EMPTY: accept -> load M, go to ONE; otherwise stay.
  - ONE, pop & accept: load M from input, stay ONE (1 per cycle throughput).
  - ONE, pop & !accept: clear M.valid, go to EMPTY.
  - ONE, !pop & accept: load S from input, go to FULL.
  - ONE, !pop & !accept: hold.
  - FULL: in_ready=0, so no accept is possible. pop -> M<=S, clear S.valid, go to ONE; !pop -> hold.
- SKID=0:
  - No S entry.
  - in_ready = !M.valid | out_ready (combinational).
  - occ is 0 or 1.
  - accept loads M; pop without accept clears M.valid.
- flush:
  - Highest priority below reset.
  - Next edge: M.valid = S.valid = 0, go to EMPTY.
  - The concurrent input is dropped, even with in_valid=1 and in_ready=1.
  - A concurrent pop completes from the consumer's view in that cycle; the entry is still cleared.
  - Data fields are unchanged by flush.
- Latency: an input accepted at edge N appears on the outputs after edge N when M was free, or after the first edge at which M pops otherwise.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush or reset.
- Width: all fields are stored bit-exact; there is no arithmetic.

Test Plan:
1. Reset: hold clrn=0 with in_valid=1, ealu=32'h1234 -> out_valid=0, mwreg=mm2reg=mwmem=0, malu=0, occ=0, in_ready=1. Release clrn -> first accepted word appears after one edge.
2. Streaming: out_ready=1; send ealu=1..8 with ern=1..8 and ewreg=1, one per cycle -> malu=1..8 in order, one cycle behind input, occ stays 1, in_ready stays 1.
3. Stall/skid (SKID=1): in ONE holding A, drop out_ready and send B -> occ=2, in_ready=0 next cycle. Send C while FULL -> C is not accepted. Raise out_ready -> A, then B, then C (after re-presentation) exit in order.
4. Bubble gating: send ewmem=1, ewreg=1, then in_valid=0 for 3 cycles -> mwmem and mwreg are 1 for exactly one cycle, then 0. malu keeps its last value.
5. Flush: in FULL (A,B), assert flush with in_valid=1 and ealu=32'hDEAD -> next cycle occ=0, out_valid=0, in_ready=1; 32'hDEAD never appears on malu.
6. SKID=0: hold out_ready=0 with M valid -> in_ready=0. Raise out_ready with in_valid=1 -> pop and accept in the same edge, occ stays 1.

Source files
------------

// File: rtl/pipe_em_elastic.sv
// pipe_em_elastic: elastic EX/MEM pipeline register with optional skid entry and flush
module pipe_em_elastic #(
  parameter int ALU_W  = 32,
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic [ALU_W-1:0]  ealu,
  input  logic [DATA_W-1:0] eb,
  input  logic [RN_W-1:0]   ern,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic [ALU_W-1:0]  malu,
  output logic [DATA_W-1:0] mb,
  output logic [RN_W-1:0]   mrn,
  output logic [1:0]        occ
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [ALU_W-1:0]  alu;
    logic [DATA_W-1:0] b;
    logic [RN_W-1:0]   rn;
  } ent_t;
  state_t st, st_nx;
  ent_t   m, s, din;
  logic   accept, pop, load_m_in, load_m_s, load_s;
  assign din       = {ewreg, em2reg, ewmem, ealu, eb, ern};
  assign out_valid = st != EMPTY;
  // SKID=1 readiness depends only on the state register; FULL is unreachable with SKID=0
  assign in_ready  = (SKID != 0) ? st != FULL : (st == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign occ       = st;
  assign load_m_in = accept & ((st == EMPTY) | pop);
  assign load_s    = (SKID != 0) & accept & (st == ONE) & ~pop;
  assign load_m_s  = ~flush & (st == FULL) & pop;
  always_comb begin
    st_nx = flush ? EMPTY :
            st == EMPTY ? (accept ? ONE : EMPTY) :
            st == ONE ? (pop ? (accept ? ONE : EMPTY) : (accept ? FULL : ONE)) :
            (pop ? ONE : FULL);
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) st <= EMPTY;
    else st <= st_nx;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) m <= '0;
    else if (load_m_in) m <= din;
    else if (load_m_s) m <= s;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) s <= '0;
    else if (load_s) s <= din;
  end
  assign mwreg  = m.wreg & out_valid;
  assign mm2reg = m.m2reg & out_valid;
  assign mwmem  = m.wmem & out_valid;
  assign malu   = m.alu;
  assign mb     = m.b;
  assign mrn    = m.rn;
endmodule
